// File: rtl/water_alert_reporter_pkg.sv
// rtl/water_alert_reporter_pkg.sv - shared status codes, frame tag and TX state encoding
package water_alert_reporter_pkg;

    localparam logic [1:0] Q_SAFE = 2'b00;
    localparam logic [1:0] Q_PH   = 2'b01;
    localparam logic [1:0] Q_TURB = 2'b10;
    localparam logic [1:0] Q_TEMP = 2'b11;

    localparam logic [1:0] FRAME_TAG = 2'b10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } tx_state_e;

    // Frame layout: tag[7:6], sequence[5:3], alert[2], quality[1:0]
    function automatic logic [7:0] make_frame(input logic [2:0] seq, input logic [2:0] status);
        return {FRAME_TAG, seq, status};
    endfunction

endpackage

// File: rtl/water_alert_reporter_uart_tx.sv
// rtl/water_alert_reporter_uart_tx.sv - 8N1 serializer, one byte per accepted handshake
module water_alert_uart_tx
    import water_alert_reporter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_out
);

    localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);

    tx_state_e  state_q,   state_d;
    logic [7:0] shift_q,   shift_d;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       bit_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // tx_out decodes straight from the state flops so an async reset returns the line high at once
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        tx_ready  = 1'b0;
        tx_busy   = 1'b1;
        tx_out    = 1'b1;
        bit_done  = (clk_cnt_q == LAST_CLK);

        if (state_q != TX_IDLE) begin
            clk_cnt_d = bit_done ? 8'd0 : clk_cnt_q + 8'd1;
        end

        case (state_q)
            TX_IDLE: begin
                tx_busy  = 1'b0;
                tx_ready = 1'b1;
                if (tx_valid) begin
                    shift_d   = tx_data;
                    clk_cnt_d = 8'd0;
                    bit_idx_d = 3'd0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                tx_out = 1'b0;
                if (bit_done) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_out = shift_q[0];
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/water_alert_reporter.sv
// rtl/water_alert_reporter.sv - debounced water quality status with queued serial event reports
module water_alert_reporter
    import water_alert_reporter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] quality_in,
    input  logic       alert_in,
    output logic       tx_out,
    output logic       tx_busy,
    output logic [1:0] confirmed_quality,
    output logic       confirmed_alert,
    output logic [7:0] event_count,
    output logic       overflow
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  DEB_MAX  = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0]  DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0] PTR_ONE  = 1;

    logic [2:0]  sample;
    logic [2:0]  cand_q,    cand_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [2:0]  conf_q,    conf_d;
    logic [7:0]  evt_cnt_q, evt_cnt_d;
    logic        ovf_q,     ovf_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q,  wr_ptr_d;
    logic [AW:0] rd_ptr_q,  rd_ptr_d;

    logic        confirm;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push_ok;
    logic        pop;
    logic        tx_ready;
    logic [7:0]  frame_byte;

    assign sample = {alert_in, quality_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q    <= 3'b000;
            cnt_q     <= DEB_MAX;
            conf_q    <= {1'b0, Q_SAFE};
            evt_cnt_q <= 8'd0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            conf_q    <= conf_d;
            evt_cnt_q <= evt_cnt_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        conf_d     = conf_q;
        evt_cnt_d  = evt_cnt_q;
        ovf_d      = ovf_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        confirm    = (sample == cand_q) && (cnt_q == DEB_LAST) && (cand_q != conf_q);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = tx_ready && !fifo_empty;
        // A pop in the same cycle frees the slot, so a full queue can still accept
        push_ok    = confirm && (!fifo_full || pop);

        if (sample != cand_q) begin
            cand_d = sample;
            cnt_d  = 4'd1;
        end else if (cnt_q != DEB_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end

        if (confirm) begin
            conf_d    = cand_q;
            evt_cnt_d = evt_cnt_q + 8'd1;
            if (!push_ok) begin
                ovf_d = 1'b1;
            end
        end

        frame_byte = make_frame(evt_cnt_d[2:0], cand_q);

        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = frame_byte;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    water_alert_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (mem_q[rd_ptr_q[AW-1:0]]),
        .tx_valid (!fifo_empty),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_out   (tx_out)
    );

    assign confirmed_quality = conf_q[1:0];
    assign confirmed_alert   = conf_q[2];
    assign event_count       = evt_cnt_q;
    assign overflow          = ovf_q;

endmodule

// File: tb/tb_water_alert_reporter.sv
// tb/tb_water_alert_reporter.sv - directed self-checking bench for water_alert_reporter
module tb_water_alert_reporter;

    localparam int DEB = 4;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] quality_in;
    logic       alert_in;
    logic       tx_out;
    logic       tx_busy;
    logic [1:0] confirmed_quality;
    logic       confirmed_alert;
    logic [7:0] event_count;
    logic       overflow;

    int         checks       = 0;
    int         errors       = 0;
    int         reset_events = 0;
    logic [7:0] rx_q[$];
    int         base;
    logic [7:0] exp_frames [5] = '{8'h8D, 8'h96, 8'h9F, 8'hA1, 8'hAA};
    logic [7:0] got_byte;

    always #5 clk = ~clk;

    always @(posedge reset) reset_events = reset_events + 1;

    water_alert_reporter #(
        .DEBOUNCE_CYCLES(DEB),
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .quality_in       (quality_in),
        .alert_in         (alert_in),
        .tx_out           (tx_out),
        .tx_busy          (tx_busy),
        .confirmed_quality(confirmed_quality),
        .confirmed_alert  (confirmed_alert),
        .event_count      (event_count),
        .overflow         (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic a, input logic [1:0] q);
        alert_in   = a;
        quality_in = q;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, rx_q.size(), n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00);
        step(2);
        reset = 1'b0;
    endtask

    // Line receiver: samples mid-bit, discards any frame cut by a reset
    initial begin : rx_monitor
        logic [7:0] b;
        int         mark;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx_out === 1'b0) begin
                mark = reset_events;
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = tx_out;
                    if (i < 7) repeat (CPB) @(negedge clk);
                end
                repeat (CPB) @(negedge clk);
                if (mark == reset_events) begin
                    check_eq("rx_stop_bit", tx_out, 1);
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00);
        step(2);
        check_eq("rst_quality", confirmed_quality, 2'b00);
        check_eq("rst_alert",   confirmed_alert,   0);
        check_eq("rst_count",   event_count,       0);
        check_eq("rst_ovf",     overflow,          0);
        check_eq("rst_tx_out",  tx_out,            1);
        check_eq("rst_busy",    tx_busy,           0);
        reset = 1'b0;

        drive(1'b1, 2'b10);
        step(3);
        drive(1'b0, 2'b00);
        step(12);
        check_eq("glitch_quality", confirmed_quality, 2'b00);
        check_eq("glitch_alert",   confirmed_alert,   0);
        check_eq("glitch_count",   event_count,       0);
        check_eq("glitch_busy",    tx_busy,           0);
        check_eq("glitch_frames",  rx_q.size(),       0);

        drive(1'b1, 2'b01);
        step(3);
        check_eq("deb_early_quality", confirmed_quality, 2'b00);
        step(1);
        check_eq("deb_quality", confirmed_quality, 2'b01);
        check_eq("deb_alert",   confirmed_alert,   1);
        check_eq("deb_count",   event_count,       1);
        check_eq("pre_pop_busy", tx_busy,          0);
        step(1);
        check_eq("start_busy",  tx_busy, 1);
        check_eq("start_level", tx_out,  0);
        wait_rx("f1_frames", 1, 100);
        got_byte = rx_q[0];
        check_eq("f1_byte", got_byte, 8'h8D);
        step(5);
        check_eq("f1_idle_busy", tx_busy, 0);

        drive(1'b0, 2'b11);
        step(22);
        check_eq("bit3_busy",  tx_busy, 1);
        check_eq("bit3_level", tx_out,  0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_tx_out", tx_out,      1);
        check_eq("abort_busy",   tx_busy,     0);
        check_eq("abort_count",  event_count, 0);
        drive(1'b0, 2'b00);
        step(3);
        reset = 1'b0;
        step(60);
        check_eq("post_abort_busy",   tx_busy,     0);
        check_eq("post_abort_count",  event_count, 0);
        check_eq("post_abort_frames", rx_q.size(), 1);

        base = rx_q.size();
        drive(1'b1, 2'b01); step(4);
        drive(1'b1, 2'b10); step(4);
        drive(1'b1, 2'b11); step(4);
        drive(1'b0, 2'b01); step(4);
        drive(1'b0, 2'b10); step(4);
        check_eq("q5_ovf", overflow, 0);
        drive(1'b0, 2'b11); step(4);
        check_eq("q6_ovf",     overflow,          1);
        check_eq("q6_count",   event_count,       6);
        check_eq("q6_quality", confirmed_quality, 2'b11);
        check_eq("q6_alert",   confirmed_alert,   0);
        wait_rx("q_frames", base + 5, 300);
        for (int i = 0; i < 5; i++) begin
            got_byte = rx_q[base + i];
            check_eq($sformatf("q_byte%0d", i), got_byte, exp_frames[i]);
        end
        step(60);
        check_eq("q_no_sixth", rx_q.size(), base + 5);

        do_reset();
        base = rx_q.size();
        drive(1'b1, 2'b01); step(4);
        drive(1'b1, 2'b10); step(4);
        drive(1'b1, 2'b11); step(4);
        drive(1'b0, 2'b01); step(4);
        drive(1'b0, 2'b10); step(26);
        drive(1'b0, 2'b11);
        step(3);
        check_eq("sim_idle_busy", tx_busy,  0);
        check_eq("sim_pre_ovf",   overflow, 0);
        step(1);
        check_eq("sim_ovf",   overflow,    0);
        check_eq("sim_count", event_count, 6);
        check_eq("sim_busy",  tx_busy,     1);
        wait_rx("sim_frames", base + 6, 400);
        got_byte = rx_q[base];
        check_eq("sim_first", got_byte, 8'h8D);
        got_byte = rx_q[base + 5];
        check_eq("sim_last", got_byte, 8'hB3);

        do_reset();
        for (int k = 0; k < 255; k++) begin
            if (k % 2 == 0) drive(1'b1, 2'b01);
            else            drive(1'b0, 2'b00);
            step(4);
        end
        check_eq("pre_wrap_count", event_count, 255);
        step(300);
        base = rx_q.size();
        drive(1'b0, 2'b00);
        step(4);
        check_eq("wrap_count", event_count, 0);
        wait_rx("wrap_frames", base + 1, 100);
        got_byte = rx_q[base];
        check_eq("wrap_byte", got_byte,      8'h80);
        check_eq("wrap_seq",  got_byte[5:3], 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/water_alert_reporter.md
WATER_ALERT_REPORTER -- requirements
Module: water_alert_reporter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive identical samples needed to confirm a status (legal range 2..15).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning event queue entries (power of 2).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 quality_in  input  2  status code: 00 safe, 01 pH fault, 10 turbidity fault, 11 temperature fault.
REQ-007 alert_in  input  1  alert flag paired with quality_in.
REQ-008 tx_out  output  1  UART-style serial line; idle high.
REQ-009 tx_busy  output  1  high while a frame is on the line.
REQ-010 confirmed_quality  output  2  debounced status code.
REQ-011 confirmed_alert  output  1  debounced alert flag.
REQ-012 event_count  output  8  count of confirmed status changes; wraps 255->0.
REQ-013 overflow  output  1  sticky; set when an event is dropped because the FIFO is full.

Function
REQ-014 Debounce: sample S={alert_in,quality_in} every cycle; if S!=candidate then candidate<=S and cnt<=1; else cnt increments, saturating at DEBOUNCE_CYCLES.
REQ-015 When S==candidate, cnt==DEBOUNCE_CYCLES-1, and candidate!={confirmed_alert,confirmed_quality}, the confirmed outputs SHALL load candidate on that edge, DEBOUNCE_CYCLES edges after S first presents.
REQ-016 Each confirmation SHALL increment event_count and push frame byte {2'b10, new event_count[2:0], alert, quality[1:0]} into the FIFO on the same edge.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no change, no push, and no count.
REQ-018 FIFO full and push with no pop: byte dropped, overflow<=1, event_count still increments.
REQ-019 Simultaneous push and pop on a full FIFO: push accepted, no overflow.
REQ-020 TX FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE with FIFO non-empty: pop the head into the shift register and enter START on the same edge.
REQ-022 START drives 0 for CLKS_PER_BIT cycles.
REQ-023 DATA drives 8 bits, LSB first, each for CLKS_PER_BIT cycles.
REQ-024 STOP drives 1 for CLKS_PER_BIT cycles, then the FSM returns to IDLE.
REQ-025 The FSM SHALL spend at least 1 cycle in IDLE between frames; frame period is 10*CLKS_PER_BIT+1 cycles.
REQ-026 tx_busy SHALL be high exactly in START, DATA and STOP; tx_out SHALL be high in IDLE.
REQ-027 A status change while tx_busy is high SHALL only queue the event; the frame in flight is never disturbed.

Reset
REQ-028 Reset SHALL set confirmed_quality=00, confirmed_alert=0, candidate=000, cnt=DEBOUNCE_CYCLES, event_count=0, overflow=0, FIFO empty, FSM=IDLE, tx_out=1, tx_busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (tx_out high asynchronously); queued events are discarded.
REQ-030 After reset release, the first confirmation SHALL occur only for a status other than 000.

Structure
REQ-031 A shared package SHALL hold the status-code constants (SAFE=00, PH=01, TURB=10, TEMP=11), the frame tag 2'b10 and the TX state enumeration.
REQ-032 The serializer SHALL be a sub-module water_alert_uart_tx (byte+valid in, ready/busy/tx_out out); debounce and FIFO SHALL stay in the top.

Verification (DEBOUNCE_CYCLES=4, CLKS_PER_BIT=4)
REQ-033 After reset, hold quality_in=01, alert_in=1 -> confirmed=01/1 after 4 edges; event_count=1; tx_out emits 0x8D: start 0, bits 1,0,1,1,0,0,0,1, stop 1, 4 cycles each.
REQ-034 From safe, apply quality_in=10/alert=1 for 3 cycles, then 00/0 -> no confirmation; event_count unchanged; tx_out stays 1.
REQ-035 Drive 6 distinct confirmed changes spaced 4 cycles apart -> 1st transmits at once, 2nd-5th queue, 6th dropped; overflow=1; event_count=6; 5 frames emitted in order.
REQ-036 Assert reset during DATA bit 3 -> tx_out=1 and tx_busy=0 at once; after release, no residual frame; event_count=0.
REQ-037 Preload event_count=255 via 255 alternating confirmations -> next confirmation wraps it to 0; frame seq field=000.
REQ-038 Push on a full FIFO in the same cycle the FSM pops -> accepted; overflow stays 0.
